// File: rtl/disp_pkg.sv
// Shared types and constants for the display-sharing arbiter.
// Ownership is a two-state FSM; clog2 sizes the owner index and the dwell counter.
package disp_pkg;

  localparam int DISP_DATA_W          = 16;
  localparam int DEFAULT_DWELL_CYCLES = 50000000;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/display_share_arbiter_rr_pick.sv
// Round-robin picker: returns the first candidate at or after ptr_i, wrapping modulo N.
// Candidates are requests with the excluded positions masked off.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  input  logic [N-1:0]     excl_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [N-1:0] cand;
  logic [N-1:0] rot;
  logic [IDX_W:0] pos;

  assign cand = req_i & ~excl_i;
  // Rotate so that bit 0 corresponds to the pointer position.
  assign rot  = N'({cand, cand} >> ptr_i);

  // Scan from the far end down so the lowest rotated offset wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    pos     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        pos = {1'b0, ptr_i} + (IDX_W + 1)'(i);
        if (pos >= (IDX_W + 1)'(N)) begin
          pos = pos - (IDX_W + 1)'(N);
        end
        found_o = 1'b1;
        idx_o   = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/display_share_arbiter.sv
// Time-shares one display value input between N_REQ requesters with round-robin
// ownership and a minimum dwell per owner; switches happen without an idle gap.
module display_share_arbiter
  import disp_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int DATA_W       = DISP_DATA_W,
  parameter int DWELL_CYCLES = DEFAULT_DWELL_CYCLES
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          i_req,
  input  logic [N_REQ*DATA_W-1:0]   i_value,
  output logic [N_REQ-1:0]          o_grant,
  output logic [clog2(N_REQ)-1:0]   o_owner,
  output logic                      o_valid,
  output logic [DATA_W-1:0]         o_display_value
);

  localparam int IDX_W = clog2(N_REQ);
  localparam int CNT_W = clog2(DWELL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL_CYCLES - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  disp_q, disp_d;

  logic [DATA_W-1:0]  val_arr [N_REQ];
  logic [N_REQ-1:0]   owner_oh;
  logic [N_REQ-1:0]   pick_excl;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   ptr_after_pick;
  logic               expired;
  logic               in_hold;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
    assign val_arr[gi]  = i_value[gi*DATA_W +: DATA_W];
    assign owner_oh[gi] = (owner_q == IDX_W'(gi));
  end

  assign in_hold = (state_q == HOLD);
  assign expired = (cnt_q == CNT_MAX);
  // While holding, the current owner never wins its own expiry re-pick.
  assign pick_excl = in_hold ? owner_oh : '0;
  assign ptr_after_pick = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);

  rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i   (i_req),
    .ptr_i   (ptr_q),
    .excl_i  (pick_excl),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = HOLD;
          owner_d = pick_idx;
          ptr_d   = ptr_after_pick;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        // Display tracks the owner with one cycle of lag and freezes on release.
        disp_d = val_arr[owner_q];
        if (expired && pick_found) begin
          owner_d = pick_idx;
          ptr_d   = ptr_after_pick;
          cnt_d   = '0;
        end else if (i_req[owner_q]) begin
          if (!expired) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_grant         = in_hold ? owner_oh : '0;
    o_valid         = in_hold;
    o_owner         = owner_q;
    o_display_value = disp_q;
  end

endmodule

// File: tb/tb_display_share_arbiter.sv
// Directed bench for display_share_arbiter with a cycle-level ownership model
// checked every cycle, plus literal expectations at key points of each scenario.
module tb_display_share_arbiter;

  localparam int N     = 4;
  localparam int DW    = 16;
  localparam int DWELL = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    i_req;
  logic [N*DW-1:0] i_value;
  logic [N-1:0]    o_grant;
  logic [1:0]      o_owner;
  logic            o_valid;
  logic [DW-1:0]   o_display_value;

  logic [DW-1:0]   val [N];
  logic [N-1:0]    rot_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Model state: owner index (-1 when idle), last owner, rr pointer, cycles held.
  int            m_owner = -1;
  int            m_last  = 0;
  int            m_ptr   = 0;
  int            m_held  = 0;
  logic [DW-1:0] m_disp  = '0;

  assign i_value = {val[3], val[2], val[1], val[0]};

  always #5 clk = ~clk;

  display_share_arbiter #(
    .N_REQ        (N),
    .DATA_W       (DW),
    .DWELL_CYCLES (DWELL)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_req           (i_req),
    .i_value         (i_value),
    .o_grant         (o_grant),
    .o_owner         (o_owner),
    .o_valid         (o_valid),
    .o_display_value (o_display_value)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int first_from(input logic [N-1:0] r, input int start, input int excl);
    for (int off = 0; off < N; off++) begin
      int idx;
      idx = (start + off) % N;
      if (r[idx] === 1'b1 && idx != excl) return idx;
    end
    return -1;
  endfunction

  // Model update on each rising edge from pre-edge inputs; compare on the falling edge.
  initial begin
    int k;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_owner = -1;
        m_last  = 0;
        m_ptr   = 0;
        m_held  = 0;
        m_disp  = '0;
      end else begin
        if (m_owner >= 0) m_disp = val[m_owner];
        k = -1;
        if (m_owner < 0) k = first_from(i_req, m_ptr, -1);
        else if (m_held >= DWELL) k = first_from(i_req, m_ptr, m_owner);
        if (k >= 0) begin
          m_owner = k;
          m_last  = k;
          m_ptr   = (k + 1) % N;
          m_held  = 1;
        end else if (m_owner >= 0) begin
          if (i_req[m_owner] === 1'b1) m_held++;
          else m_owner = -1;
        end
      end
      @(negedge clk);
      if (chk_en) begin
        check("grant", o_grant, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        check("valid", o_valid, (m_owner >= 0) ? 32'd1 : 32'd0);
        check("owner", o_owner, m_last);
        check("display", o_display_value, m_disp);
        check("onehot", ($countones(o_grant) <= 1) ? 32'd1 : 32'd0, 32'd1);
      end
    end
  end

  initial begin
    rst   = 1'b1;
    i_req = '0;
    foreach (val[i]) val[i] = '0;

    // Reset held for three cycles with random requests.
    for (int c = 0; c < 3; c++) begin
      i_req = 4'($urandom_range(0, 15));
      tick();
      chk_en = 1'b1;
    end
    check("rst_grant", o_grant, 32'h0);
    check("rst_valid", o_valid, 32'h0);
    check("rst_disp", o_display_value, 32'h0);
    check("rst_owner", o_owner, 32'h0);
    $display("step reset: grant=%b valid=%b disp=%h", o_grant, o_valid, o_display_value);

    // Single requester.
    rst    = 1'b0;
    i_req  = 4'b0001;
    val[0] = 16'h1234;
    tick();
    check("single_grant", o_grant, 32'b0001);
    check("single_disp_lag", o_display_value, 32'h0000);
    tick();
    check("single_disp", o_display_value, 32'h1234);
    repeat (10) tick();
    check("single_keep", o_grant, 32'b0001);
    $display("step single: grant=%b disp=%h", o_grant, o_display_value);

    // Rotation with all four requesting.
    rst   = 1'b1;
    i_req = '0;
    tick();
    rst   = 1'b0;
    i_req = 4'b1111;
    val   = '{16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D};
    for (int t = 1; t <= 20; t++) begin
      tick();
      check("rot_grant", o_grant, rot_exp[(t - 1) / 4]);
      if (t == 6) check("rot_disp", o_display_value, 32'h0B0B);
    end
    $display("step rotation: grant=%b owner=%0d", o_grant, o_owner);

    // Early drop by owner 2, then wrap-around pick.
    rst   = 1'b1;
    i_req = '0;
    tick();
    rst   = 1'b0;
    i_req = 4'b0100;
    tick();
    check("drop_grant2", o_grant, 32'b0100);
    tick();
    i_req = 4'b0000;
    tick();
    check("drop_grant0", o_grant, 32'b0000);
    check("drop_valid", o_valid, 32'h0);
    val[2] = 16'hFFFF;
    tick();
    check("drop_frozen", o_display_value, 32'h0C0C);
    i_req = 4'b0011;
    tick();
    check("wrap_grant", o_grant, 32'b0001);
    check("wrap_owner", o_owner, 32'h0);
    $display("step early-drop: grant=%b disp=%h", o_grant, o_display_value);

    // Switch exactly at dwell expiry.
    i_req  = 4'b0001;
    val[2] = 16'h5A5A;
    tick();
    tick();
    i_req = 4'b0101;
    tick();
    check("exp_hold", o_grant, 32'b0001);
    tick();
    check("exp_switch", o_grant, 32'b0100);
    check("exp_disp_old", o_display_value, 32'h0A0A);
    tick();
    check("exp_disp_new", o_display_value, 32'h5A5A);
    $display("step expiry-switch: grant=%b disp=%h", o_grant, o_display_value);

    // Reset in the middle of a hold.
    rst   = 1'b1;
    i_req = '0;
    tick();
    rst   = 1'b0;
    i_req = 4'b1111;
    tick();
    check("mid_grant", o_grant, 32'b0001);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("mid_rst_grant", o_grant, 32'h0);
    check("mid_rst_valid", o_valid, 32'h0);
    check("mid_rst_owner", o_owner, 32'h0);
    check("mid_rst_disp", o_display_value, 32'h0);
    rst = 1'b0;
    tick();
    check("after_rst_grant", o_grant, 32'b0001);
    $display("step reset-mid-hold: grant=%b", o_grant);

    // Saturated owner stays alone, then hands over as it drops.
    i_req = 4'b0001;
    repeat (6) tick();
    check("sat_keep", o_grant, 32'b0001);
    i_req = 4'b1000;
    tick();
    check("handover_grant", o_grant, 32'b1000);
    check("handover_valid", o_valid, 32'h1);
    repeat (3) tick();
    i_req = 4'b0000;
    tick();
    check("release_grant", o_grant, 32'h0);
    check("release_owner", o_owner, 32'h3);
    $display("step handover: grant=%b owner=%0d", o_grant, o_owner);

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
